pipe_controller: RTL and testbench

PIPE_CONTROLLER -- requirements
Module: pipe_controller

---
 rtl/pipe_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_pipe_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// Purpose : RV32I(+M) pipeline controller: ID decode, ID/EX/MEM/WB control registers, branch resolve.
// Latency : decode is combinational in ID; controls reach the WB outputs 3 cycles after ID with no stall.
// Backpr. : MulBusyE holds ID/EX for MUL_LAT-1 cycles per multiply and sends bubbles into EX/MEM meanwhile.
//
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   opD, funct3D, funct7D                ID-stage instruction fields
//   ZeroE, LtE, LtuE                     EX-stage ALU compare flags
//   FlushE                               hazard-unit flush of ID/EX (ignored while MulBusyE)
//   ImmSrcD, IllegalD                    ID immediate select, unsupported-instruction flag
//   ALUSrcE, ALUControlE, ResultSrcE0    EX controls (ResultSrcE0 marks a load for load-use detection)
//   PCSrcE, PCTargetSrcE                 redirect enable, target select (1 = ALU result, jalr)
//   MulBusyE                             multiply occupying EX
//   MemWriteM, RegWriteM                 MEM controls
//   RegWriteW, ResultSrcW                WB controls (00 ALU, 01 mem, 10 PC+4, 11 imm)
// Build option: define CTRL_MULDIV_EN to decode mul/mulh/mulhsu/mulhu and enable the multi-cycle EX hold.
module pipe_controller #(
  parameter int ALUC_W  = 4,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [6:0]        opD,
  input  logic [2:0]        funct3D,
  input  logic [6:0]        funct7D,
  input  logic              ZeroE,
  input  logic              LtE,
  input  logic              LtuE,
  input  logic              FlushE,
  output logic [2:0]        ImmSrcD,
  output logic              IllegalD,
  output logic              ALUSrcE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              ResultSrcE0,
  output logic              PCSrcE,
  output logic              PCTargetSrcE,
  output logic              MulBusyE,
  output logic              MemWriteM,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW
);

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              alu_src;
    logic              jalr;
    logic [ALUC_W-1:0] alu_ctrl;
    logic [2:0]        funct3;
`ifdef CTRL_MULDIV_EN
    logic              is_mul;
`endif
  } idex_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } memwb_t;

  // 4-bit ALU codes, zero-extended to the configured width.
  function automatic logic [ALUC_W-1:0] alu_code(input logic [3:0] c);
    return ALUC_W'(c);
  endfunction

  // funct3 -> ALU op; 'alt' is funct7[5], which means sub only for R-type.
  function automatic logic [ALUC_W-1:0] alu_op(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  return (is_r && alt) ? alu_code(4'b0001) : alu_code(4'b0000);
      3'b001:  return alu_code(4'b0111);
      3'b010:  return alu_code(4'b0101);
      3'b011:  return alu_code(4'b0110);
      3'b100:  return alu_code(4'b0100);
      3'b101:  return alt ? alu_code(4'b1001) : alu_code(4'b1000);
      3'b110:  return alu_code(4'b0011);
      default: return alu_code(4'b0010);
    endcase
  endfunction

  idex_t  ctrl_d, idex;
  exmem_t exmem;
  memwb_t memwb;
  logic   legal;

  // ---------------- ID decode ----------------
  always_comb begin
    ctrl_d  = '0;
    ImmSrcD = 3'b000;
    legal   = 1'b1;
    ctrl_d.funct3 = funct3D;
    case (opD)
      7'b0000011: begin // lw
        legal = (funct3D == 3'b010);
        ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.result_src = 2'b01;
      end
      7'b0100011: begin // sw
        legal = (funct3D == 3'b010);
        ImmSrcD = 3'b001; ctrl_d.mem_write = 1'b1; ctrl_d.alu_src = 1'b1;
      end
      7'b0110011: begin // R-type
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = alu_op(funct3D, funct7D[5], 1'b1);
        if (funct7D == 7'b0000000)
          legal = 1'b1;
        else if (funct7D == 7'b0100000)
          legal = (funct3D == 3'b000) || (funct3D == 3'b101);
`ifdef CTRL_MULDIV_EN
        else if (funct7D == 7'b0000001 && !funct3D[2]) begin
          ctrl_d.is_mul   = 1'b1;
          ctrl_d.alu_ctrl = alu_code({2'b11, funct3D[1:0]});
        end
`endif
        else
          legal = 1'b0;
      end
      7'b0010011: begin // I-type ALU; shifts constrain funct7
        ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1;
        ctrl_d.alu_ctrl  = alu_op(funct3D, funct7D[5], 1'b0);
        if (funct3D == 3'b001)
          legal = (funct7D == 7'b0000000);
        else if (funct3D == 3'b101)
          legal = (funct7D == 7'b0000000) || (funct7D == 7'b0100000);
      end
      7'b1100011: begin // branch; ALU subtracts to produce the flags
        legal = (funct3D[2:1] != 2'b01);
        ImmSrcD = 3'b010; ctrl_d.branch = 1'b1; ctrl_d.alu_ctrl = alu_code(4'b0001);
      end
      7'b1101111: begin // jal
        ImmSrcD = 3'b011; ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1; ctrl_d.result_src = 2'b10;
      end
      7'b1100111: begin // jalr
        legal = (funct3D == 3'b000);
        ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1; ctrl_d.jalr = 1'b1;
        ctrl_d.alu_src = 1'b1; ctrl_d.result_src = 2'b10;
      end
      7'b0110111: begin // lui
        ImmSrcD = 3'b100; ctrl_d.reg_write = 1'b1; ctrl_d.result_src = 2'b11;
      end
      default: legal = 1'b0;
    endcase
    // Illegal instructions travel down the pipe as a bubble.
    if (!legal) ctrl_d = '0;
  end

  assign IllegalD = ~legal;

  // ---------------- multiply occupancy ----------------
`ifdef CTRL_MULDIV_EN
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  logic [CNT_W-1:0] mul_cnt;

  // Loaded on the edge a multiply enters EX; the multiply leaves EX on the edge after it reads 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      mul_cnt <= '0;
    else if (mul_cnt != '0)
      mul_cnt <= mul_cnt - CNT_W'(1);
    else if (!FlushE && ctrl_d.is_mul)
      mul_cnt <= CNT_W'(MUL_LAT - 1);
  end

  assign MulBusyE = idex.is_mul && (mul_cnt != '0);
`else
  assign MulBusyE = 1'b0;
`endif

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      // A busy multiply owns EX, so the hold wins over a flush.
      if (!MulBusyE) idex <= FlushE ? '0 : ctrl_d;
      if (MulBusyE)
        exmem <= '0;
      else begin
        exmem.reg_write  <= idex.reg_write;
        exmem.result_src <= idex.result_src;
        exmem.mem_write  <= idex.mem_write;
      end
      memwb.reg_write  <= exmem.reg_write;
      memwb.result_src <= exmem.result_src;
    end
  end

  // ---------------- EX branch resolve ----------------
  logic cond;
  always_comb begin
    case (idex.funct3)
      3'b000:  cond = ZeroE;
      3'b001:  cond = ~ZeroE;
      3'b100:  cond = LtE;
      3'b101:  cond = ~LtE;
      3'b110:  cond = LtuE;
      3'b111:  cond = ~LtuE;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrcE       = (idex.branch & cond) | idex.jump;
  assign PCTargetSrcE = idex.jalr;
  assign ALUSrcE      = idex.alu_src;
  assign ALUControlE  = idex.alu_ctrl;
  assign ResultSrcE0  = idex.result_src[0];
  assign MemWriteM    = exmem.mem_write;
  assign RegWriteM    = exmem.reg_write;
  assign RegWriteW    = memwb.reg_write;
  assign ResultSrcW   = memwb.result_src;

endmodule

// File: tb/tb_pipe_controller.sv
// Purpose : directed self-checking bench for pipe_controller.
// Latency : one instruction presented in ID per clock; outputs sampled 1 time unit after the rising edge.
// Backpr. : the bench plays the hazard unit, keeping a stalled instruction on the ID inputs.
module tb_pipe_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opD;
  logic [2:0] funct3D;
  logic [6:0] funct7D;
  logic       ZeroE, LtE, LtuE, FlushE;
  logic [2:0] ImmSrcD;
  logic       IllegalD, ALUSrcE, ResultSrcE0, PCSrcE, PCTargetSrcE, MulBusyE;
  logic [3:0] ALUControlE;
  logic       MemWriteM, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcW;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_controller #(.ALUC_W(4), .MUL_LAT(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .opD(opD), .funct3D(funct3D), .funct7D(funct7D),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .FlushE(FlushE),
    .ImmSrcD(ImmSrcD), .IllegalD(IllegalD),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .PCTargetSrcE(PCTargetSrcE), .MulBusyE(MulBusyE),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
  );

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I  = 7'b0010011, OP_B  = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_IDLE = 7'b0000000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opD = op; funct3D = f3; funct7D = f7;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0; FlushE = 1'b0;
    set_id(OP_LUI, 3'b000, 7'b0);
    #12;
    // reset state
    check("rst_regwritew", 32'(RegWriteW), 32'd0);
    check("rst_regwritem", 32'(RegWriteM), 32'd0);
    check("rst_memwritem", 32'(MemWriteM), 32'd0);
    check("rst_aluctrl",   32'(ALUControlE), 32'd0);
    check("rst_resultsrcw", 32'(ResultSrcW), 32'd0);
    check("rst_mulbusy",   32'(MulBusyE), 32'd0);
    check("rst_pcsrc",     32'(PCSrcE), 32'd0);

    // combinational ID decode
    #1 check("lui_imm", 32'(ImmSrcD), 32'd4);
    check("lui_legal", 32'(IllegalD), 32'd0);
    set_id(OP_SW, 3'b010, 7'b0); #1 check("sw_imm", 32'(ImmSrcD), 32'd1);
    set_id(OP_B, 3'b001, 7'b0);  #1 check("b_imm", 32'(ImmSrcD), 32'd2);
    set_id(OP_JAL, 3'b000, 7'b0); #1 check("jal_imm", 32'(ImmSrcD), 32'd3);
    set_id(7'b1111111, 3'b000, 7'b0); #1 check("bad_op_illegal", 32'(IllegalD), 32'd1);
    set_id(OP_R, 3'b000, 7'b0100000); #1 check("sub_legal", 32'(IllegalD), 32'd0);
    set_id(OP_R, 3'b001, 7'b0100000); #1 check("r_alt_sll_illegal", 32'(IllegalD), 32'd1);
    set_id(OP_I, 3'b001, 7'b0100000); #1 check("slli_f7_illegal", 32'(IllegalD), 32'd1);
    set_id(OP_R, 3'b000, 7'b0000001);
`ifdef CTRL_MULDIV_EN
    #1 check("mul_legal", 32'(IllegalD), 32'd0);
`else
    #1 check("mul_illegal", 32'(IllegalD), 32'd1);
`endif

    // release, lui latency ID -> WB
    @(negedge clk) reset_n = 1'b1;
    set_id(OP_LUI, 3'b000, 7'b0);
    tick(); check("lui_e_rs0", 32'(ResultSrcE0), 32'd1);
    set_id(OP_LUI, 3'b000, 7'b0);
    tick(); check("lui_m_rw", 32'(RegWriteM), 32'd1);
    set_id(OP_IDLE, 3'b000, 7'b0);
    tick(); check("lui_w_rw", 32'(RegWriteW), 32'd1);
    check("lui_w_rs", 32'(ResultSrcW), 32'd3);
    // mid-stream reset clears E/M/W immediately
    #2 reset_n = 1'b0;
    #1 check("midrst_rww", 32'(RegWriteW), 32'd0);
    check("midrst_rwm", 32'(RegWriteM), 32'd0);
    check("midrst_rsw", 32'(ResultSrcW), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    set_id(OP_LUI, 3'b000, 7'b0);
    tick(); set_id(OP_IDLE, 3'b000, 7'b0);
    tick(); check("post_rst_w_early", 32'(RegWriteW), 32'd0);
    tick(); check("post_rst_w_3cyc", 32'(RegWriteW), 32'd1);
    tick(); tick();

    // ALU control selection
    set_id(OP_R, 3'b000, 7'b0100000); tick();
    check("sub_aluc", 32'(ALUControlE), 32'h1);
    check("sub_alusrc", 32'(ALUSrcE), 32'd0);
    set_id(OP_I, 3'b101, 7'b0100000); tick();
    check("srai_aluc", 32'(ALUControlE), 32'h9);
    check("srai_alusrc", 32'(ALUSrcE), 32'd1);
    set_id(OP_I, 3'b000, 7'b0100000); tick();
    check("addi_f7_aluc", 32'(ALUControlE), 32'h0);
    set_id(OP_R, 3'b111, 7'b0); tick();
    check("and_aluc", 32'(ALUControlE), 32'h2);

    // branches
    set_id(OP_B, 3'b001, 7'b0); tick();
    ZeroE = 1'b0; #1 check("bne_nz_pcsrc", 32'(PCSrcE), 32'd1);
    check("bne_tgt", 32'(PCTargetSrcE), 32'd0);
    ZeroE = 1'b1; #1 check("bne_z_pcsrc", 32'(PCSrcE), 32'd0);
    ZeroE = 1'b0;
    set_id(OP_B, 3'b110, 7'b0); tick();
    LtuE = 1'b1; LtE = 1'b0; #1 check("bltu_pcsrc", 32'(PCSrcE), 32'd1);
    set_id(OP_B, 3'b101, 7'b0); tick();
    LtuE = 1'b0; LtE = 1'b1; #1 check("bge_lt_pcsrc", 32'(PCSrcE), 32'd0);
    LtE = 1'b0; #1 check("bge_ge_pcsrc", 32'(PCSrcE), 32'd1);

    // jalr
    set_id(OP_JALR, 3'b000, 7'b0); tick();
    check("jalr_pcsrc", 32'(PCSrcE), 32'd1);
    check("jalr_tgt", 32'(PCTargetSrcE), 32'd1);
    set_id(OP_IDLE, 3'b000, 7'b0);
    tick(); tick();
    check("jalr_w_rs", 32'(ResultSrcW), 32'd2);
    check("jalr_w_rw", 32'(RegWriteW), 32'd1);

    // lw then flush
    set_id(OP_LW, 3'b010, 7'b0); tick();
    check("lw_e_rs0", 32'(ResultSrcE0), 32'd1);
    set_id(OP_I, 3'b110, 7'b0); FlushE = 1'b1;
    tick(); FlushE = 1'b0;
    check("flush_rs0", 32'(ResultSrcE0), 32'd0);
    check("flush_alusrc", 32'(ALUSrcE), 32'd0);
    check("flush_aluc", 32'(ALUControlE), 32'd0);
    check("flush_lw_m", 32'(RegWriteM), 32'd1);
    set_id(OP_IDLE, 3'b000, 7'b0); tick();
    check("flush_bubble_m", 32'(RegWriteM), 32'd0);
    check("lw_w_rs", 32'(ResultSrcW), 32'd1);
    tick(); tick();

`ifdef CTRL_MULDIV_EN
    // multiply holds EX for MUL_LAT cycles; flush during the hold is ignored
    set_id(OP_R, 3'b000, 7'b0000001); tick();
    check("mul_aluc", 32'(ALUControlE), 32'hC);
    check("mul_busy1", 32'(MulBusyE), 32'd1);
    set_id(OP_SW, 3'b010, 7'b0); FlushE = 1'b1;
    tick(); FlushE = 1'b0;
    check("mul_busy2", 32'(MulBusyE), 32'd1);
    check("mul_hold_aluc", 32'(ALUControlE), 32'hC);
    check("mul_bubble_m", 32'(RegWriteM), 32'd0);
    tick();
    check("mul_busy_done", 32'(MulBusyE), 32'd0);
    check("mul_last_aluc", 32'(ALUControlE), 32'hC);
    check("mul_last_m", 32'(RegWriteM), 32'd0);
    tick();
    check("mul_m_rw", 32'(RegWriteM), 32'd1);
    check("sw_after_mul_e", 32'(ALUSrcE), 32'd1);
    set_id(OP_IDLE, 3'b000, 7'b0); tick();
    check("mul_m_once", 32'(RegWriteM), 32'd0);
    check("sw_m_memw", 32'(MemWriteM), 32'd1);
    tick(); tick();
    // reset aborts an in-flight multiply
    set_id(OP_R, 3'b011, 7'b0000001); tick();
    check("mulhu_aluc", 32'(ALUControlE), 32'hF);
    set_id(OP_IDLE, 3'b000, 7'b0);
    reset_n = 1'b0;
    #1 check("abort_busy", 32'(MulBusyE), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_wb", 32'({RegWriteM, RegWriteW}), 32'd0);
    end
`else
    // multiply encodings are bubbles in this build
    set_id(OP_R, 3'b000, 7'b0000001); tick();
    check("nomul_busy", 32'(MulBusyE), 32'd0);
    check("nomul_aluc", 32'(ALUControlE), 32'd0);
    set_id(OP_IDLE, 3'b000, 7'b0); tick();
    check("nomul_m", 32'(RegWriteM), 32'd0);
    tick();
    check("nomul_w", 32'(RegWriteW), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
